// File: rtl/jtopl_regwr_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jtopl_regwr_pkg
// Purpose  : Shared FSM encoding, wait-counter sizing and default bus-timing
//            constants for the OPL register-write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package jtopl_regwr_pkg;

    // Width of the cen-pulse wait counter (waits of 1..127 pulses)
    localparam int unsigned c_cnt_w = 7;

    // Default number of cen pulses the core needs after each bus write
    localparam int unsigned c_addr_wait_default = 12;
    localparam int unsigned c_data_wait_default = 84;

    typedef logic [c_cnt_w-1:0] wait_cnt_t;

    // Sequencer states: address strobe/wait, then data strobe/wait
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ASTB  = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DSTB  = 3'd3,
        ST_DWAIT = 3'd4
    } state_t;

    // Converts a wait length into a counter load value. Out-of-range values
    // are clamped so a zero wait can never wrap the counter to 127.
    function automatic wait_cnt_t wait_load(input int unsigned pulses);
        wait_cnt_t w_load;
        if (pulses < 1) begin
            w_load = wait_cnt_t'(1);
        end else if (pulses > 127) begin
            w_load = wait_cnt_t'(127);
        end else begin
            w_load = wait_cnt_t'(pulses);
        end
        return w_load;
    endfunction

endpackage : jtopl_regwr_pkg
`default_nettype wire

// File: rtl/jtopl_regwr.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_regwr
// Purpose  : Turns one register-write request into the two-phase OPL bus
//            sequence (address-port write, wait, data-port write, wait),
//            with all timing counted in cen pulses of the sound core. Also
//            samples the core status byte and interrupt line.
// Revision : 1.0 - initial release
// ============================================================================
module jtopl_regwr
    import jtopl_regwr_pkg::*;
#(
    parameter int unsigned ADDR_WAIT = c_addr_wait_default,  // 1..127
    parameter int unsigned DATA_WAIT = c_data_wait_default   // 1..127
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    // request side
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_val,
    // core bus side
    output logic [7:0] opl_din,
    output logic       opl_addr,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    input  logic [7:0] opl_dout,
    input  logic       opl_irq_n,
    // status side
    output logic [7:0] status,
    output logic       irq,
    output logic       busy
);

    localparam wait_cnt_t c_addr_load = wait_load(ADDR_WAIT);
    localparam wait_cnt_t c_data_load = wait_load(DATA_WAIT);

    state_t    r_state;
    wait_cnt_t r_cnt;
    logic [7:0] r_val;
    logic [7:0] r_din;
    logic       r_addr;
    logic       r_cs_n;
    logic       r_wr_n;
    logic [7:0] r_status;
    logic       r_irq;

    // Last wait pulse: the counter is loaded with N and the N-th cen edge
    // (counter reaching 1) ends the wait, so a wait is exactly N pulses.
    logic w_cnt_last;
    assign w_cnt_last = (r_cnt <= wait_cnt_t'(1));

    // Sequencer: bus strobes are registered and set on the edge entering
    // the strobe state, so they are glitch-free and aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_val   <= '0;
            r_din   <= '0;
            r_addr  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Acceptance does not wait for cen; the strobe does.
                    if (req_valid) begin
                        r_val   <= req_val;
                        r_din   <= req_reg;
                        r_addr  <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_state <= ST_ASTB;
                    end
                end

                ST_ASTB: begin
                    // Strobe spans exactly one cen-qualified edge
                    if (cen) begin
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_cnt   <= c_addr_load;
                        r_state <= ST_AWAIT;
                    end
                end

                ST_AWAIT: begin
                    if (cen) begin
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_din   <= r_val;
                            r_addr  <= 1'b1;
                            r_cs_n  <= 1'b0;
                            r_wr_n  <= 1'b0;
                            r_state <= ST_DSTB;
                        end else begin
                            r_cnt <= r_cnt - wait_cnt_t'(1);
                        end
                    end
                end

                ST_DSTB: begin
                    if (cen) begin
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_cnt   <= c_data_load;
                        r_state <= ST_DWAIT;
                    end
                end

                ST_DWAIT: begin
                    // Bus address/data stay on the last written values
                    if (cen) begin
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - wait_cnt_t'(1);
                        end
                    end
                end

                default: begin
                    // Unused encodings recover to a quiet bus in IDLE
                    r_cnt   <= '0;
                    r_cs_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status byte is only refreshed while the bus is idle, so a read never
    // observes the core mid-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (cen && (r_state == ST_IDLE)) begin
            r_status <= opl_dout;
        end
    end

    // Interrupt is resampled on every cen edge regardless of bus activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (cen) begin
            r_irq <= ~opl_irq_n;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign opl_din   = r_din;
    assign opl_addr  = r_addr;
    assign opl_cs_n  = r_cs_n;
    assign opl_wr_n  = r_wr_n;
    assign status    = r_status;
    assign irq       = r_irq;

endmodule : jtopl_regwr
`default_nettype wire
